// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath; the slave side is hazard_unit.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic [4:0]       Rs1_E;
    logic [4:0]       Rs2_E;
    logic [4:0]       Rd_E;
    logic             RegWrite_E;
    logic             MemRead_E;
    logic             PCSrc_E;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic             Stall_F;
    logic             Stall_D;
    logic             Flush_D;
    logic             Flush_E;
    logic [4:0]       Rd_M;
    logic [4:0]       Rd_W;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, RegWrite_E, MemRead_E, PCSrc_E,
        input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Flush_D, Flush_E,
        input  Rd_M, Rd_W, StallCount, FlushCount
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, RegWrite_E, MemRead_E, PCSrc_E,
        output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Flush_D, Flush_E,
        output Rd_M, Rd_W, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch flush control with a private MEM/WB
// destination-tag shadow pipeline and saturating stall/flush event counters.
module hazard_unit #(
    parameter int unsigned CNT_W = 32
) (
    input logic         clk,
    input logic         rst_n,
    hazard_unit_if.slave hz
);
    logic [4:0]       rd_m_q, rd_w_q;
    logic             reg_write_m_q, reg_write_w_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use;
    logic             stall;

    // MEM stage wins over WB when both hold the same destination.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        load_use = hz.MemRead_E && (hz.Rd_E != 5'd0) &&
                   ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
        // A redirect flushes the dependent instruction, so no stall is needed.
        stall    = load_use && !hz.PCSrc_E;
    end

    assign hz.ForwardA_E = fwd_sel(hz.Rs1_E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    assign hz.ForwardB_E = fwd_sel(hz.Rs2_E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    assign hz.Stall_F    = stall;
    assign hz.Stall_D    = stall;
    assign hz.Flush_D    = hz.PCSrc_E;
    assign hz.Flush_E    = load_use || hz.PCSrc_E;
    assign hz.Rd_M       = rd_m_q;
    assign hz.Rd_W       = rd_w_q;
    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

    // Tags advance every cycle; an E-stage bubble arrives as RegWrite_E = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_m_q        <= 5'd0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= 5'd0;
            reg_write_w_q <= 1'b0;
        end else begin
            rd_m_q        <= hz.Rd_E;
            reg_write_m_q <= hz.RegWrite_E;
            rd_w_q        <= rd_m_q;
            reg_write_w_q <= reg_write_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (hz.PCSrc_E && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; expectations are queued by the
// stimulus process and compared by a monitor on the falling clock edge.
module tb_hazard_unit;
    localparam int unsigned CW = 4;

    typedef struct {
        int         id;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fd;
        logic       fe;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   vec_id;
    exp_t exp_q[$];

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec %0d got %0h want %0h", name, id, act, want);
        end
    endtask

    // Monitor: combinational outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ForwardA_E", e.id, 32'(hz.ForwardA_E), 32'(e.fa));
            chk("ForwardB_E", e.id, 32'(hz.ForwardB_E), 32'(e.fb));
            chk("Stall_F",    e.id, 32'(hz.Stall_F),    32'(e.st));
            chk("Stall_D",    e.id, 32'(hz.Stall_D),    32'(e.st));
            chk("Flush_D",    e.id, 32'(hz.Flush_D),    32'(e.fd));
            chk("Flush_E",    e.id, 32'(hz.Flush_E),    32'(e.fe));
            chk("Rd_M",       e.id, 32'(hz.Rd_M),       32'(e.rdm));
            chk("Rd_W",       e.id, 32'(hz.Rd_W),       32'(e.rdw));
            chk("StallCount", e.id, 32'(hz.StallCount), 32'(e.sc));
            chk("FlushCount", e.id, 32'(hz.FlushCount), 32'(e.fc));
        end
    end

    task automatic drive(input logic rn, input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rs1e, input logic [4:0] rs2e,
                         input logic [4:0] rde, input logic rw, input logic mr,
                         input logic pc);
        @(posedge clk);
        #1;
        rst_n         = rn;
        hz.Rs1_D      = rs1d;
        hz.Rs2_D      = rs2d;
        hz.Rs1_E      = rs1e;
        hz.Rs2_E      = rs2e;
        hz.Rd_E       = rde;
        hz.RegWrite_E = rw;
        hz.MemRead_E  = mr;
        hz.PCSrc_E    = pc;
    endtask

    task automatic expect_out(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input logic fd, input logic fe, input logic [4:0] rdm,
                              input logic [4:0] rdw, input logic [3:0] sc,
                              input logic [3:0] fc);
        exp_t e;
        vec_id++;
        e.id  = vec_id;
        e.fa  = fa;
        e.fb  = fb;
        e.st  = st;
        e.fd  = fd;
        e.fe  = fe;
        e.rdm = rdm;
        e.rdw = rdw;
        e.sc  = sc;
        e.fc  = fc;
        exp_q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec_id = 0;
        rst_n  = 1'b0;
        hz.Rs1_D = 5'd0; hz.Rs2_D = 5'd0; hz.Rs1_E = 5'd0; hz.Rs2_E = 5'd0;
        hz.Rd_E = 5'd0; hz.RegWrite_E = 1'b0; hz.MemRead_E = 1'b0; hz.PCSrc_E = 1'b0;

        // Reset held while E writes x5: nothing may be captured.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0);
            expect_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        end
        // Release: no forwarding until one edge has captured x5.
        drive(1'b1, 0, 0, 5, 0, 5, 1'b1, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 5, 0, 5, 1'b1, 1'b0, 1'b0);
        expect_out(2'b10, 2'b00, 0, 0, 0, 5, 0, 0, 0);
        // x5 in both MEM and WB: MEM wins.
        drive(1'b1, 0, 0, 5, 0, 7, 1'b1, 1'b0, 1'b0);
        expect_out(2'b10, 2'b00, 0, 0, 0, 5, 5, 0, 0);
        // x5 only in WB now.
        drive(1'b1, 0, 0, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b01, 2'b00, 0, 0, 0, 7, 5, 0, 0);

        // Mixed: M=5, W=6 gives A=10, B=01.
        drive(1'b1, 0, 0, 0, 0, 6, 1'b1, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 0, 7, 0, 0);
        drive(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 6, 0, 0, 0);
        drive(1'b1, 0, 0, 5, 6, 0, 1'b1, 1'b0, 1'b0);
        expect_out(2'b10, 2'b01, 0, 0, 0, 5, 6, 0, 0);
        // Write to x0 sits in MEM; x0 readers see no forwarding.
        drive(1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 0, 5, 0, 0);
        // Load to x0 never stalls.
        drive(1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rs2: one-cycle stall, then bubble, then WB forward.
        drive(1'b1, 1, 9, 0, 0, 9, 1'b1, 1'b1, 1'b0);
        expect_out(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0);
        drive(1'b1, 1, 9, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 9, 0, 1, 0);
        drive(1'b1, 0, 0, 0, 9, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b01, 0, 0, 0, 0, 9, 1, 0);

        // Branch during load-use: redirect wins over the stall.
        drive(1'b1, 1, 9, 0, 0, 9, 1'b1, 1'b1, 1'b1);
        expect_out(2'b00, 2'b00, 0, 1, 1, 0, 0, 1, 0);
        drive(1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 9, 0, 1, 1);

        // Saturation: 20 stall cycles from a count of 1 must stop at 15.
        for (int k = 1; k <= 20; k++) begin
            logic [4:0] m;
            logic [4:0] w;
            m = (k == 1) ? 5'd0 : 5'd9;
            w = (k == 2) ? 5'd0 : 5'd9;
            drive(1'b1, 0, 9, 0, 0, 9, 1'b1, 1'b1, 1'b0);
            expect_out(2'b00, 2'b00, 1, 0, 1, m, w, (k < 15) ? 4'(k) : 4'd15, 1);
        end
        drive(1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 9, 9, 15, 1);

        // Mid-operation reset clears state at once; stall/flush still follow inputs.
        drive(1'b0, 9, 0, 0, 0, 9, 1'b1, 1'b1, 1'b0);
        expect_out(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 9, 9, 0, 1'b0, 1'b0, 1'b0);
        expect_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", vec_id, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout vec %0d got running want finished", vec_id);
        $fatal(1);
    end
endmodule
